// File: rtl/tl_pkg.sv
// Shared constants for the traffic-light bus monitor: light codes, directions,
// fault codes, FSM state encoding and the lane bundle type.
package tl_pkg;

    localparam logic [1:0] LT_RED     = 2'b00;
    localparam logic [1:0] LT_YELLOW  = 2'b01;
    localparam logic [1:0] LT_GREEN   = 2'b10;
    localparam logic [1:0] LT_ILLEGAL = 2'b11;

    localparam logic [1:0] NS_DIR = 2'd0;
    localparam logic [1:0] EW_DIR = 2'd1;
    localparam logic [1:0] SN_DIR = 2'd2;
    localparam logic [1:0] WE_DIR = 2'd3;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_CONFLICT   = 3'd1;
    localparam logic [2:0] FC_ILLEGAL    = 3'd2;
    localparam logic [2:0] FC_SEQUENCE   = 3'd3;
    localparam logic [2:0] FC_GREEN_LEN  = 3'd4;
    localparam logic [2:0] FC_YELLOW_LEN = 3'd5;
    localparam logic [2:0] FC_STALL      = 3'd6;

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    typedef struct packed {
        logic [1:0] ns;
        logic [1:0] sn;
        logic [1:0] ew;
        logic [1:0] we;
    } lanes_t;

    // Rotation order NS -> EW -> SN -> WE -> NS follows the direction encoding.
    function automatic logic [1:0] next_dir(input logic [1:0] d);
        return d + 2'd1;
    endfunction

endpackage

// File: rtl/tl_light_decode.sv
// Combinational decode of the four registered lanes into direction, phase and
// the valid / gap / conflict / illegal classification.
module tl_light_decode
    import tl_pkg::*;
(
    input  lanes_t     lanes_i,
    output logic [1:0] dir_o,
    output logic       phase_o,
    output logic       valid_o,
    output logic       gap_o,
    output logic       conflict_o,
    output logic       illegal_o
);

    logic [3:0][1:0] lane_c;
    logic [2:0]      n_c;
    logic [1:0]      sel_c;

    always_comb begin
        lane_c         = '0;
        lane_c[NS_DIR] = lanes_i.ns;
        lane_c[EW_DIR] = lanes_i.ew;
        lane_c[SN_DIR] = lanes_i.sn;
        lane_c[WE_DIR] = lanes_i.we;
        n_c        = '0;
        sel_c      = LT_RED;
        dir_o      = NS_DIR;
        illegal_o  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lane_c[i] != LT_RED) begin
                n_c   = n_c + 3'd1;
                dir_o = 2'(i);
                sel_c = lane_c[i];
            end
            if (lane_c[i] == LT_ILLEGAL) begin
                illegal_o = 1'b1;
            end
        end
        phase_o    = (sel_c == LT_YELLOW);
        valid_o    = (n_c == 3'd1) && ((sel_c == LT_GREEN) || (sel_c == LT_YELLOW));
        gap_o      = (n_c == 3'd0);
        conflict_o = (n_c >= 3'd2);
    end

endmodule

// File: rtl/tl_light_monitor.sv
// Passive checker on the NS/SN/EW/WE light buses; latches the first fault.
// Define TL_MON_TIMING_EN to build the green/yellow length and stall checks.
module tl_light_monitor
    import tl_pkg::*;
#(
    parameter int unsigned GREEN_LEN  = 6,
    parameter int unsigned YELLOW_LEN = 3,
    parameter int unsigned STALL_MAX  = 4,
    parameter int unsigned RCNT_W     = 16
) (
    input  logic              CLK,
    input  logic              CLEAR,
    input  logic [1:0]        NS,
    input  logic [1:0]        SN,
    input  logic [1:0]        EW,
    input  logic [1:0]        WE,
    output logic [1:0]        active_dir,
    output logic              phase_yellow,
    output logic              in_sync,
    output logic              fault,
    output logic [2:0]        fault_code,
    output logic [RCNT_W-1:0] rotations
);

    lanes_t            lanes_q;
    logic [1:0]        state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic              yel_q, yel_d;
    logic              sync_q, sync_d;
    logic              fault_q, fault_d;
    logic [2:0]        code_q, code_d;
    logic [RCNT_W-1:0] rot_q, rot_d;
    logic [2:0]        code_c;
    logic              same_c, succ_c;

    logic [1:0] dec_dir;
    logic       dec_yel, dec_valid, dec_gap, dec_conflict, dec_illegal;

`ifdef TL_MON_TIMING_EN
    localparam logic [7:0] GREEN_LIM  = 8'(GREEN_LEN);
    localparam logic [7:0] YELLOW_LIM = 8'(YELLOW_LEN);
    localparam logic [7:0] STALL_LIM  = 8'(STALL_MAX);

    logic [7:0] run_q, run_d;
    logic [7:0] gap_q, gap_d;
    logic       first_q, first_d;
`else
    wire unused_timing_params = ^{32'(GREEN_LEN), 32'(YELLOW_LEN), 32'(STALL_MAX)};
`endif

    // Input stage: every decision below works on these registered lanes.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= {NS, SN, EW, WE};
        end
    end

    tl_light_decode u_decode (
        .lanes_i    (lanes_q),
        .dir_o      (dec_dir),
        .phase_o    (dec_yel),
        .valid_o    (dec_valid),
        .gap_o      (dec_gap),
        .conflict_o (dec_conflict),
        .illegal_o  (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        yel_d   = yel_q;
        sync_d  = sync_q;
        fault_d = fault_q;
        code_d  = code_q;
        rot_d   = rot_q;
        code_c  = FC_NONE;
`ifdef TL_MON_TIMING_EN
        run_d   = run_q;
        gap_d   = gap_q;
        first_d = first_q;
`endif
        same_c = dec_valid && (dec_dir == dir_q) && (dec_yel == yel_q);
        succ_c = (state_q == ST_YELLOW)
               ? (dec_valid && !dec_yel && (dec_dir == next_dir(dir_q)))
               : (dec_valid &&  dec_yel && (dec_dir == dir_q));

        case (state_q)
            ST_SYNC: begin
                if (dec_conflict) begin
                    code_c = FC_CONFLICT;
                end else if (dec_illegal) begin
                    code_c = FC_ILLEGAL;
                end else if (dec_valid && !dec_yel) begin
                    state_d = ST_GREEN;
                    dir_d   = dec_dir;
                    yel_d   = 1'b0;
                    sync_d  = 1'b1;
`ifdef TL_MON_TIMING_EN
                    run_d   = 8'd1;
                    gap_d   = 8'd0;
                    first_d = 1'b1;
`endif
                end
            end
            ST_GREEN, ST_YELLOW: begin
                if (dec_conflict) begin
                    code_c = FC_CONFLICT;
                end else if (dec_illegal) begin
                    code_c = FC_ILLEGAL;
                end else if (dec_gap) begin
                    // A gap pauses the current phase rather than ending it.
`ifdef TL_MON_TIMING_EN
                    if (gap_q >= STALL_LIM) begin
                        code_c = FC_STALL;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
`endif
                end else if (same_c) begin
`ifdef TL_MON_TIMING_EN
                    if (run_q != 8'hFF) begin
                        run_d = run_q + 8'd1;
                    end
                    gap_d = 8'd0;
`endif
                end else if (succ_c) begin
`ifdef TL_MON_TIMING_EN
                    if (!first_q && (state_q == ST_GREEN) && (run_q != GREEN_LIM)) begin
                        code_c = FC_GREEN_LEN;
                    end else if (!first_q && (state_q == ST_YELLOW) && (run_q != YELLOW_LIM)) begin
                        code_c = FC_YELLOW_LEN;
                    end
`endif
                    if (code_c == FC_NONE) begin
                        state_d = (state_q == ST_YELLOW) ? ST_GREEN : ST_YELLOW;
                        dir_d   = dec_dir;
                        yel_d   = dec_yel;
                        if ((state_q == ST_YELLOW) && (dir_q == WE_DIR) && (rot_q != '1)) begin
                            rot_d = rot_q + RCNT_W'(1);
                        end
`ifdef TL_MON_TIMING_EN
                        run_d   = 8'd1;
                        gap_d   = 8'd0;
                        first_d = 1'b0;
`endif
                    end
                end else begin
                    code_c = FC_SEQUENCE;
                end
            end
            default: begin
            end
        endcase

        if (code_c != FC_NONE) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = code_c;
        end
    end

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q <= ST_SYNC;
            dir_q   <= NS_DIR;
            yel_q   <= 1'b0;
            sync_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            rot_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            yel_q   <= yel_d;
            sync_q  <= sync_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            rot_q   <= rot_d;
        end
    end

`ifdef TL_MON_TIMING_EN
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            run_q   <= 8'd0;
            gap_q   <= 8'd0;
            first_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            gap_q   <= gap_d;
            first_q <= first_d;
        end
    end
`endif

    assign active_dir   = dir_q;
    assign phase_yellow = yel_q;
    assign in_sync      = sync_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;
    assign rotations    = rot_q;

endmodule

// File: tb/tb_tl_light_monitor.sv
// Directed bench for tl_light_monitor; expectations follow TL_MON_TIMING_EN.
module tb_tl_light_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;

`ifdef TL_MON_TIMING_EN
    localparam bit TIMED = 1'b1;
`else
    localparam bit TIMED = 1'b0;
`endif

    logic        CLK;
    logic        CLEAR;
    logic [1:0]  NS, SN, EW, WE;
    logic [1:0]  active_dir;
    logic        phase_yellow;
    logic        in_sync;
    logic        fault;
    logic [2:0]  fault_code;
    logic [15:0] rotations;

    int total;
    int bad;

    tl_light_monitor dut (
        .CLK          (CLK),
        .CLEAR        (CLEAR),
        .NS           (NS),
        .SN           (SN),
        .EW           (EW),
        .WE           (WE),
        .active_dir   (active_dir),
        .phase_yellow (phase_yellow),
        .in_sync      (in_sync),
        .fault        (fault),
        .fault_code   (fault_code),
        .rotations    (rotations)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one direction with a light code (d < 0 means all red) for n cycles.
    task automatic ph(input int d, input logic [1:0] c, input int n);
        logic [3:0][1:0] l;
        l = '0;
        if (d >= 0) l[d[1:0]] = c;
        NS = l[0];
        EW = l[1];
        SN = l[2];
        WE = l[3];
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        ph(-1, R, 0);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        NS = R; SN = R; EW = R; WE = R;
        CLEAR = 1'b1;
        @(negedge CLK);
        chk("rst_dir", 32'(active_dir), 0);
        chk("rst_yel", 32'(phase_yellow), 0);
        chk("rst_sync", 32'(in_sync), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_code", 32'(fault_code), 0);
        chk("rst_rot", 32'(rotations), 0);
        CLEAR = 1'b0;

        // Eight clean rotations starting from NS green.
        ph(0, G, 1);
        chk("t1_sync_early", 32'(in_sync), 0);
        ph(0, G, 1);
        chk("t1_sync", 32'(in_sync), 1);
        chk("t1_dir", 32'(active_dir), 0);
        ph(0, G, 4);
        ph(0, Y, 3);
        for (int r = 0; r < 8; r++) begin
            for (int d = 1; d < 4; d++) begin
                ph(d, G, 6);
                ph(d, Y, 3);
            end
            ph(0, G, 6);
            chk($sformatf("t1_rot%0d", r), 32'(rotations), 32'(r + 1));
            if (r < 7) ph(0, Y, 3);
        end
        chk("t1_fault", 32'(fault), 0);
        chk("t1_code", 32'(fault_code), 0);
        chk("t1_yel", 32'(phase_yellow), 0);

        // One-cycle conflict during NS green.
        do_reset();
        ph(0, G, 3);
        NS = G; EW = G;
        @(negedge CLK);
        chk("t2_pre", 32'(fault), 0);
        ph(0, G, 1);
        chk("t2_fault", 32'(fault), 1);
        chk("t2_code", 32'(fault_code), 1);
        ph(0, G, 2);
        ph(0, Y, 3);
        ph(1, G, 6);
        chk("t2_code_hold", 32'(fault_code), 1);
        chk("t2_dir_hold", 32'(active_dir), 0);
        chk("t2_sync", 32'(in_sync), 1);

        // Wrong successor: SN green after NS green.
        do_reset();
        ph(0, G, 6);
        ph(2, G, 2);
        chk("t3_code", 32'(fault_code), 3);
        chk("t3_dir", 32'(active_dir), 0);
        chk("t3_yel", 32'(phase_yellow), 0);

        // Short second green.
        do_reset();
        ph(0, G, 6);
        ph(0, Y, 3);
        ph(1, G, 5);
        ph(1, Y, 2);
        chk("t4_fault", 32'(fault), TIMED ? 1 : 0);
        chk("t4_code", 32'(fault_code), TIMED ? 4 : 0);
        chk("t4_dir", 32'(active_dir), 1);
        chk("t4_yel", 32'(phase_yellow), TIMED ? 0 : 1);

        // Short yellow after the first (unchecked) green.
        do_reset();
        ph(0, G, 6);
        ph(0, Y, 2);
        ph(1, G, 2);
        chk("t4b_code", 32'(fault_code), TIMED ? 5 : 0);
        chk("t4b_dir", 32'(active_dir), TIMED ? 0 : 1);

        // Five-cycle all-red stall.
        do_reset();
        ph(0, G, 6);
        ph(0, Y, 3);
        ph(-1, R, 4);
        chk("t5_gap_dir", 32'(active_dir), 0);
        chk("t5_gap_yel", 32'(phase_yellow), 1);
        chk("t5_gap_fault", 32'(fault), 0);
        ph(-1, R, 2);
        chk("t5_code", 32'(fault_code), TIMED ? 6 : 0);

        // Four-cycle gap is tolerated.
        do_reset();
        ph(0, G, 6);
        ph(0, Y, 3);
        ph(-1, R, 4);
        ph(1, G, 3);
        chk("t5b_fault", 32'(fault), 0);
        chk("t5b_dir", 32'(active_dir), 1);
        chk("t5b_yel", 32'(phase_yellow), 0);

        // CLEAR mid EW green, then resync on a truncated green.
        do_reset();
        ph(0, G, 6);
        ph(0, Y, 3);
        ph(1, G, 3);
        chk("t6_pre_sync", 32'(in_sync), 1);
        CLEAR = 1'b1;
        #1;
        chk("t6_clr_dir", 32'(active_dir), 0);
        chk("t6_clr_sync", 32'(in_sync), 0);
        chk("t6_clr_fault", 32'(fault), 0);
        @(negedge CLK);
        CLEAR = 1'b0;
        ph(1, G, 3);
        ph(1, Y, 3);
        ph(2, G, 6);
        chk("t6_fault", 32'(fault), 0);
        chk("t6_dir", 32'(active_dir), 2);
        chk("t6_sync", 32'(in_sync), 1);
        ph(2, Y, 3);
        ph(3, G, 6);
        chk("t6_fault2", 32'(fault), 0);
        chk("t6_dir2", 32'(active_dir), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_light_monitor.md
Name: tl_light_monitor

Overview:
- Passive checker on the 2-bit light buses (NS, SN, EW, WE) driven by the four-direction traffic-light controller.
- Decodes which direction is active and in which phase, and enforces the safety, sequencing and timing rules.
- Latches the first violation as a sticky fault and counts completed rotations.
- Sits beside the controller in the top level and in benches as a protocol checker; it drives nothing back to the controller.

Parameters:
- GREEN_LEN, 6: required green dwell in clock cycles.
- YELLOW_LEN, 3: required yellow dwell in clock cycles.
- STALL_MAX, 4: maximum consecutive all-red cycles tolerated.
- RCNT_W, 16: width of the rotation counter.

Ports:
- CLK  in  1  system clock, rising edge.
- CLEAR  in  1  asynchronous, active-high reset.
- NS  in  2  north-south light code (00 red, 01 yellow, 10 green, 11 illegal).
- SN  in  2  south-north light code.
- EW  in  2  east-west light code.
- WE  in  2  west-east light code.
- active_dir  out  2  current direction (0 NS, 1 EW, 2 SN, 3 WE).
- phase_yellow  out  1  0 = green, 1 = yellow; valid only when in_sync = 1.
- in_sync  out  1  monitor has locked onto the sequence.
- fault  out  1  sticky; cleared only by CLEAR.
- fault_code  out  3  code of the first fault; 0 = none.
- rotations  out  RCNT_W  completed WE-yellow to NS-green transitions; saturating.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high; all outputs 0; FSM enters SYNC.
- Stage 1 registers the four light inputs every cycle.
- Decision logic uses only the registered values.
- Latency: a value present before edge k is sampled at k; any resulting output change is visible after edge k+1 (2-cycle latency).
- Decode:
  - exactly one lane non-red gives a valid dir/phase;
  - two or more non-red lanes is a conflict;
  - any lane at 11 is illegal;
  - all lanes red is a gap.
- run_cnt counts consecutive identical sampled (dir, phase) cycles. It resets to 1 on change and saturates at 255.
- gap_cnt counts consecutive all-red cycles.
- FSM states: SYNC, GREEN, YELLOW, FAULT.
- SYNC:
  - waits for the first valid green on any direction;
  - moves to GREEN and sets in_sync;
  - the first phase is not length-checked (partial observation).
- GREEN(d): legal next value is YELLOW on the same d.
- YELLOW(d): legal next value is GREEN on (d+1) mod 4, wrapping WE to NS.
- On each legal transition, the run length of the phase just ended is compared with GREEN_LEN or YELLOW_LEN.
- rotations increments on a YELLOW(3) to GREEN(0) transition and holds at all-ones.
- Gaps are legal only while gap_cnt ≤ STALL_MAX. A gap does not end a phase; the phase following the gap must still be a legal successor.
- Fault codes:
  - 1 conflict
  - 2 illegal code
  - 3 sequence (wrong successor)
  - 4 green length
  - 5 yellow length
  - 6 stall
- Simultaneous faults in one cycle: the lowest code wins.
- Any fault: set fault, capture fault_code, enter FAULT.
- FAULT is absorbing until CLEAR. active_dir and phase_yellow hold their last values; later faults are ignored.
- A CLEAR mid-phase returns to SYNC; the partial phase seen after release is not length-checked.
- The monitor never faults while in SYNC, except for conflict or illegal code.

Optional Feature:
- Macro: TL_MON_TIMING_EN.
- Defined: length checks (codes 4, 5) and the stall check (code 6) are active.
- Undefined: only conflict, illegal and sequence checks are built. run_cnt and gap_cnt are removed, and codes 4–6 never occur.

Decomposition:
- Package tl_pkg holds:
  - light codes RED/YELLOW/GREEN/ILLEGAL;
  - direction codes NS_DIR..WE_DIR;
  - fault code constants;
  - FSM state encoding.
- Sub-module tl_light_decode is combinational and maps the four registered lanes to dir, phase, valid, gap, conflict and illegal.

Test Plan:
- Controller-like stimulus, GREEN 6 / YELLOW 3, 8 full rotations → fault = 0, rotations = 8 after the last NS-green, in_sync = 1 two cycles after the first green.
- NS = 10 and EW = 10 together for 1 cycle during NS green → fault_code = 1, asserted 2 edges later; subsequent legal traffic leaves the code unchanged.
- NS green 6 cycles, then SN green instead of NS yellow → fault_code = 3.
- Second green (EW) held 5 cycles, then EW yellow → fault_code = 4. With TL_MON_TIMING_EN undefined, the same stimulus gives fault = 0.
- All lanes red for 5 cycles after NS yellow → fault_code = 6. A 4-cycle gap followed by EW green → no fault.
- CLEAR pulsed mid-EW-green → all outputs 0 and SYNC immediately. A truncated first green of 3 cycles is accepted, and the next yellow is timed normally.
